// File: rtl/reg_access_seq.sv
// reg_access_seq: host command sequencer for a 16x32 register file with burst reads and a 2-entry response FIFO
module reg_access_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rf_read_en,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic [DATA_W:0]   mem_q [2];
  logic [DATA_W:0]   mem_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              accept, pop, issue_ok;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      beats_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      mem_q[0]        <= '0;
      mem_q[1]        <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      beats_q         <= beats_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      mem_q[0]        <= mem_d[0];
      mem_q[1]        <= mem_d[1];
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE)  ? (accept ? (cmd_write ? WRITE : READ) : IDLE) :
              (state_q == WRITE) ? IDLE :
              (rf_read_en && beats_q == '0) ? IDLE : READ;
  end
  always_comb begin
    cmd_ready     = state_q == IDLE && !rst;
    rf_write_en   = state_q == WRITE;
    rf_read_en    = state_q == READ && issue_ok;
    rf_addr       = addr_q;
    rf_write_data = wdata_q;
    rsp_valid     = count_q != '0;
    {rsp_data, rsp_last} = mem_q[rd_ptr_q];
    busy          = state_q != IDLE || inflight_q || rsp_valid;
  end
  always_comb begin
    accept          = cmd_valid && cmd_ready;
    pop             = rsp_valid && rsp_ready;
    issue_ok        = ({1'b0, count_q} + {2'b0, inflight_q}) < ({2'b0, pop} + 3'd2);
    addr_d          = accept ? cmd_addr : rf_read_en ? addr_q + ADDR_W'(1) : addr_q;
    wdata_d         = (accept && cmd_write) ? cmd_wdata : wdata_q;
    beats_d         = (accept && !cmd_write) ? cmd_len : rf_read_en ? beats_q - LEN_W'(1) : beats_q;
    inflight_d      = rf_read_en;
    inflight_last_d = rf_read_en && beats_q == '0;
    mem_d[0]        = (inflight_q && !wr_ptr_q) ? {rf_read_data, inflight_last_q} : mem_q[0];
    mem_d[1]        = (inflight_q && wr_ptr_q) ? {rf_read_data, inflight_last_q} : mem_q[1];
    wr_ptr_d        = wr_ptr_q ^ inflight_q;
    rd_ptr_d        = rd_ptr_q ^ pop;
    count_d         = count_q + {1'b0, inflight_q} - {1'b0, pop};
  end
endmodule

// File: tb/tb_reg_access_seq.sv
// tb_reg_access_seq: scoreboard and vector-table bench for reg_access_seq
module tb_reg_access_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rf_read_en, rf_write_en;
  logic [3:0]  rf_addr;
  logic [31:0] rf_write_data;
  logic [31:0] rf_read_data = '0;
  logic        busy;
  logic [31:0] rf_mem [16];
  logic [31:0] shadow [16];
  logic [32:0] q [$];
  int          checks = 0;
  int          errors = 0;
  int          mode = 0;
  int          rd_pulses = 0;
  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [9];
  reg_access_seq dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rf_read_en(rf_read_en), .rf_write_en(rf_write_en), .rf_addr(rf_addr),
    .rf_write_data(rf_write_data), .rf_read_data(rf_read_data), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rf_write_en) rf_mem[rf_addr] <= rf_write_data;
    rf_read_data <= rf_read_en ? rf_mem[rf_addr] : 32'hBAD0_0BAD;
  end
  initial forever begin
    @(posedge clk);
    #1;
    rsp_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  initial begin : monitor
    logic        stalled;
    logic [32:0] held;
    logic [32:0] e;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) stalled = 1'b0;
      else begin
        chk("rd_wr_exclusive", 32'(rf_read_en && rf_write_en), 32'd0);
        chk("ready_while_active", 32'(cmd_ready && (rf_read_en || rf_write_en)), 32'd0);
        if (stalled) chk("stall_stable", {rsp_data[30:0], rsp_last}, {held[31:1], held[0]});
        if (stalled) chk("stall_stable_msb", 32'(rsp_data[31]), 32'(held[32]));
        if (rsp_valid && rsp_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: got data %h last %b expected none", rsp_data, rsp_last);
          end else begin
            e = q.pop_front();
            chk("rsp_data", rsp_data, e[32:1]);
            chk("rsp_last", 32'(rsp_last), 32'(e[0]));
          end
        end
        stalled = rsp_valid && !rsp_ready;
        held = {rsp_data, rsp_last};
        if (rf_read_en) rd_pulses++;
      end
    end
  end
  task automatic send(input logic wr, input logic [3:0] addr, input logic [3:0] len,
                      input logic [31:0] wdata, input logic auto_exp, output logic ok);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr = addr;
    cmd_len = len;
    cmd_wdata = wdata;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout: got cmd_ready 0 expected 1 within 300 cycles");
    end else if (wr) shadow[addr] = wdata;
    else if (auto_exp)
      for (int i = 0; i <= int'(len); i++) q.push_back({shadow[4'(int'(addr) + i)], i == int'(len)});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask
  task automatic drain;
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_left", 32'(q.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask
  initial begin
    logic ok;
    logic [31:0] a14 [6];
    tbl[0] = '{1'b1, 4'd9, 32'h0BAD_F00D, 32'h0};
    tbl[1] = '{1'b0, 4'd9, 32'h0, 32'h0BAD_F00D};
    tbl[2] = '{1'b1, 4'd9, 32'h1234_5678, 32'h0};
    tbl[3] = '{1'b0, 4'd9, 32'h0, 32'h1234_5678};
    tbl[4] = '{1'b1, 4'd2, 32'hFFFF_FFFF, 32'h0};
    tbl[5] = '{1'b1, 4'd4, 32'h0, 32'h0};
    tbl[6] = '{1'b0, 4'd2, 32'h0, 32'hFFFF_FFFF};
    tbl[7] = '{1'b0, 4'd4, 32'h0, 32'h0};
    tbl[8] = '{1'b0, 4'd3, 32'h0, 32'hDEAD_BEEF};
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rf_read_en", 32'(rf_read_en), 32'd0);
    chk("rst_rf_write_en", 32'(rf_write_en), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_last", 32'(rsp_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rf_addr", 32'(rf_addr), 32'd0);
    chk("rst_rf_write_data", rf_write_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    mode = 1;
    for (int i = 0; i < 16; i++) send(1'b1, 4'(i), 4'd0, 32'h1111_1111 * i, 1'b1, ok);
    send(1'b1, 4'd3, 4'd0, 32'hDEAD_BEEF, 1'b1, ok);
    @(negedge clk);
    chk("wr_t1_write_en", 32'(rf_write_en), 32'd1);
    chk("wr_t1_read_en", 32'(rf_read_en), 32'd0);
    chk("wr_t1_addr", 32'(rf_addr), 32'd3);
    chk("wr_t1_wdata", rf_write_data, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_t2_write_en", 32'(rf_write_en), 32'd0);
    chk("wr_t2_cmd_ready", 32'(cmd_ready), 32'd1);
    send(1'b0, 4'd3, 4'd0, 32'h0, 1'b1, ok);
    @(negedge clk);
    chk("rd_t1_read_en", 32'(rf_read_en), 32'd1);
    chk("rd_t1_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rd_t2_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rd_t3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_t3_rsp_data", rsp_data, 32'hDEAD_BEEF);
    chk("rd_t3_rsp_last", 32'(rsp_last), 32'd1);
    drain();
    foreach (tbl[i]) begin
      send(tbl[i].wr, tbl[i].addr, 4'd0, tbl[i].wdata, 1'b0, ok);
      if (ok && !tbl[i].wr) q.push_back({tbl[i].exp, 1'b1});
    end
    drain();
    send(1'b1, 4'd14, 4'd0, 32'hA, 1'b1, ok);
    send(1'b1, 4'd15, 4'd0, 32'hB, 1'b1, ok);
    send(1'b1, 4'd0, 4'd0, 32'hC, 1'b1, ok);
    send(1'b1, 4'd1, 4'd0, 32'hD, 1'b1, ok);
    send(1'b0, 4'd14, 4'd3, 32'h0, 1'b1, ok);
    a14[0] = 32'd14; a14[1] = 32'd15; a14[2] = 32'd0; a14[3] = 32'd1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("burst_read_en", 32'(rf_read_en), 32'(i < 4));
      if (i < 4) chk("burst_rf_addr", 32'(rf_addr), a14[i]);
      chk("burst_rsp_valid", 32'(rsp_valid), 32'(i >= 2));
      if (i >= 2) chk("burst_rsp_last", 32'(rsp_last), 32'(i == 5));
    end
    drain();
    for (int i = 2; i < 8; i++) send(1'b1, 4'(i), 4'd0, 32'h100 + i, 1'b1, ok);
    mode = 0;
    @(posedge clk);
    rd_pulses = 0;
    send(1'b0, 4'd0, 4'd7, 32'h0, 1'b1, ok);
    repeat (8) @(negedge clk);
    chk("stall_read_pulses", 32'(rd_pulses), 32'd2);
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("stall_head_data", rsp_data, 32'hC);
    mode = 1;
    drain();
    send(1'b0, 4'd0, 4'd15, 32'h0, 1'b1, ok);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_cmd_ready_after", 32'(cmd_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    send(1'b0, 4'd5, 4'd0, 32'h0, 1'b1, ok);
    drain();
    mode = 2;
    for (int i = 0; i < 1000; i++) begin
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           $urandom, 1'b1, ok);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    mode = 1;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
